// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: control-step sequencer for MUL/DIV on the mini_cpu data_path.
// Runs rb->Y, rc+op->Z, Zlow->LO/GPR, Zhigh->HI/GPR, then pulses done.
// Ports:
//   clk_i            system clock, rising edge
//   clear_i          synchronous active-low reset
//   start_i          request pulse, accepted only in IDLE
//   is_div_i         0 = multiply, 1 = divide (latched on accept)
//   rb_i, rc_i       operand register indices (latched on accept)
//   to_gpr_i         0 = write back to LO/HI, 1 = write back to GPRs
//   rd_lo_i, rd_hi_i GPR targets for Zlow/Zhigh when to_gpr_i=1
//   rout_o, rin_o    one-hot GPR bus-out / load enables
//   yin_o, zhighin_o, zlowin_o, zhighout_o, zlowout_o, hiin_o, loin_o  strobes
//   op_o             ALU operation select
//   busy_o, done_o   sequence in progress / one-cycle completion pulse
module muldiv_sequencer #(
  parameter logic [4:0]  OP_MUL   = 5'b01010,
  parameter logic [4:0]  OP_DIV   = 5'b01011,
  parameter int unsigned ALU_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic        is_div_i,
  input  logic [3:0]  rb_i,
  input  logic [3:0]  rc_i,
  input  logic        to_gpr_i,
  input  logic [3:0]  rd_lo_i,
  input  logic [3:0]  rd_hi_i,
  output logic [15:0] rout_o,
  output logic [15:0] rin_o,
  output logic        yin_o,
  output logic [4:0]  op_o,
  output logic        zhighin_o,
  output logic        zlowin_o,
  output logic        zhighout_o,
  output logic        zlowout_o,
  output logic        hiin_o,
  output logic        loin_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned NREG      = 16;
  localparam logic [3:0]  WAIT_LAST = 4'(ALU_WAIT % 16);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_Y, S_EXEC, S_WB_LO, S_WB_HI, S_DONE
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              is_div_q, to_gpr_q;
  logic [3:0]        rb_q, rc_q, rd_lo_q, rd_hi_q;
  logic [NREG-1:0]   rout_q, rin_q;
  logic [4:0]        op_q;
  logic              yin_q, zload_q, zhout_q, zlout_q, hiin_q, loin_q, busy_q, done_q;

  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Outputs are registered alongside the state they belong to: each
  // transition loads the strobes of the state being entered.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      to_gpr_q <= 1'b0;
      rb_q     <= '0;
      rc_q     <= '0;
      rd_lo_q  <= '0;
      rd_hi_q  <= '0;
      rout_q   <= '0;
      rin_q    <= '0;
      op_q     <= '0;
      yin_q    <= 1'b0;
      zload_q  <= 1'b0;
      zhout_q  <= 1'b0;
      zlout_q  <= 1'b0;
      hiin_q   <= 1'b0;
      loin_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rout_q  <= '0;
      rin_q   <= '0;
      op_q    <= '0;
      yin_q   <= 1'b0;
      zload_q <= 1'b0;
      zhout_q <= 1'b0;
      zlout_q <= 1'b0;
      hiin_q  <= 1'b0;
      loin_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            is_div_q <= is_div_i;
            to_gpr_q <= to_gpr_i;
            rb_q     <= rb_i;
            rc_q     <= rc_i;
            rd_lo_q  <= rd_lo_i;
            rd_hi_q  <= rd_hi_i;
            state_q  <= S_LOAD_Y;
            rout_q   <= onehot(rb_i);
            yin_q    <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD_Y: begin
          state_q <= S_EXEC;
          cnt_q   <= '0;
          rout_q  <= onehot(rc_q);
          op_q    <= is_div_q ? OP_DIV : OP_MUL;
          zload_q <= (WAIT_LAST == 4'd0);
          busy_q  <= 1'b1;
        end
        S_EXEC: begin
          busy_q <= 1'b1;
          if (cnt_q == WAIT_LAST) begin
            state_q <= S_WB_LO;
            zlout_q <= 1'b1;
            if (to_gpr_q) rin_q  <= onehot(rd_lo_q);
            else          loin_q <= 1'b1;
          end else begin
            // Z strobe is pre-loaded so it lands on the last EXEC cycle.
            cnt_q   <= 4'(cnt_q + 4'd1);
            rout_q  <= onehot(rc_q);
            op_q    <= is_div_q ? OP_DIV : OP_MUL;
            zload_q <= (4'(cnt_q + 4'd1) == WAIT_LAST);
          end
        end
        S_WB_LO: begin
          state_q <= S_WB_HI;
          zhout_q <= 1'b1;
          busy_q  <= 1'b1;
          if (to_gpr_q) rin_q  <= onehot(rd_hi_q);
          else          hiin_q <= 1'b1;
        end
        S_WB_HI: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rout_o     = rout_q;
  assign rin_o      = rin_q;
  assign yin_o      = yin_q;
  assign op_o       = op_q;
  assign zhighin_o  = zload_q;
  assign zlowin_o   = zload_q;
  assign zhighout_o = zhout_q;
  assign zlowout_o  = zlout_q;
  assign hiin_o     = hiin_q;
  assign loin_o     = loin_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: two instances (ALU_WAIT 0 and 3) share inputs.
// A phase-timeline model gives expected outputs each cycle, and a small
// data_path model driven by the DUT strobes checks arithmetic results.
module tb_muldiv_sequencer;

  localparam int         W0  = 0;
  localparam int         W1  = 3;
  localparam logic [4:0] MUL = 5'b01010;
  localparam logic [4:0] DIV = 5'b01011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, start, is_div, to_gpr;
  logic [3:0] rb, rc, rd_lo, rd_hi;

  logic [15:0] rout[2], rin[2];
  logic [4:0]  op[2];
  logic        yin[2], zhin[2], zlin[2], zhout[2], zlout[2], hiin[2], loin[2], busy[2], done[2];

  muldiv_sequencer #(.ALU_WAIT(W0)) u_dut0 (
    .clk_i(clk), .clear_i(clear), .start_i(start), .is_div_i(is_div),
    .rb_i(rb), .rc_i(rc), .to_gpr_i(to_gpr), .rd_lo_i(rd_lo), .rd_hi_i(rd_hi),
    .rout_o(rout[0]), .rin_o(rin[0]), .yin_o(yin[0]), .op_o(op[0]),
    .zhighin_o(zhin[0]), .zlowin_o(zlin[0]), .zhighout_o(zhout[0]), .zlowout_o(zlout[0]),
    .hiin_o(hiin[0]), .loin_o(loin[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  muldiv_sequencer #(.ALU_WAIT(W1)) u_dut1 (
    .clk_i(clk), .clear_i(clear), .start_i(start), .is_div_i(is_div),
    .rb_i(rb), .rc_i(rc), .to_gpr_i(to_gpr), .rd_lo_i(rd_lo), .rd_hi_i(rd_hi),
    .rout_o(rout[1]), .rin_o(rin[1]), .yin_o(yin[1]), .op_o(op[1]),
    .zhighin_o(zhin[1]), .zlowin_o(zlin[1]), .zhighout_o(zhout[1]), .zlowout_o(zlout[1]),
    .hiin_o(hiin[1]), .loin_o(loin[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  typedef struct packed {
    logic [15:0] rout;
    logic [15:0] rin;
    logic        yin;
    logic [4:0]  op;
    logic        zhin, zlin, zhout, zlout, hiin, loin, busy, done;
  } outs_t;

  typedef struct packed {
    logic       is_div, to_gpr;
    logic [3:0] rb, rc, rd_lo, rd_hi;
  } req_t;

  // Model: t = cycles since accept (1 = LOAD_Y cycle), -1 when idle.
  int   t[2];
  req_t fld[2];

  logic [31:0] gpr[2][16];
  logic [31:0] y_r[2], zhi[2], zlo[2], hi_r[2], lo_r[2];

  int total, bad, cycle, acc;
  int done_cnt[2], last_done[2];

  function automatic int w_of(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic outs_t actual(input int d);
    return {rout[d], rin[d], yin[d], op[d], zhin[d], zlin[d], zhout[d], zlout[d],
            hiin[d], loin[d], busy[d], done[d]};
  endfunction

  // Expected outputs from the position in the sequence timeline.
  function automatic outs_t expect_out(input int tt, input int w, input req_t f);
    outs_t e;
    e = '0;
    if (tt == 1) begin
      e.rout = 16'(1) << f.rb;
      e.yin  = 1'b1;
      e.busy = 1'b1;
    end else if (tt >= 2 && tt <= w + 2) begin
      e.rout = 16'(1) << f.rc;
      e.op   = f.is_div ? DIV : MUL;
      e.busy = 1'b1;
      e.zhin = (tt == w + 2);
      e.zlin = (tt == w + 2);
    end else if (tt == w + 3) begin
      e.zlout = 1'b1;
      e.busy  = 1'b1;
      if (f.to_gpr) e.rin = 16'(1) << f.rd_lo;
      else          e.loin = 1'b1;
    end else if (tt == w + 4) begin
      e.zhout = 1'b1;
      e.busy  = 1'b1;
      if (f.to_gpr) e.rin = 16'(1) << f.rd_hi;
      else          e.hiin = 1'b1;
    end else if (tt == w + 5) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // One clock: apply data_path effects of current strobes, advance, compare.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] bus;
      bus = '0;
      for (int i = 0; i < 16; i++) if (rout[d][i]) bus = gpr[d][i];
      if (zlout[d]) bus = zlo[d];
      if (zhout[d]) bus = zhi[d];
      if (yin[d]) y_r[d] = bus;
      if (zhin[d] && zlin[d]) begin
        if (op[d] == DIV) begin
          zlo[d] = (bus != 0) ? y_r[d] / bus : 32'd0;
          zhi[d] = (bus != 0) ? y_r[d] % bus : 32'd0;
        end else begin
          {zhi[d], zlo[d]} = 64'(y_r[d]) * 64'(bus);
        end
      end
      for (int i = 0; i < 16; i++) if (rin[d][i]) gpr[d][i] = bus;
      if (loin[d]) lo_r[d] = bus;
      if (hiin[d]) hi_r[d] = bus;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!clear) t[d] = -1;
      else if (t[d] == -1) begin
        if (start) begin
          t[d]   = 1;
          fld[d] = {is_div, to_gpr, rb, rc, rd_lo, rd_hi};
        end
      end else begin
        t[d]++;
        if (t[d] > w_of(d) + 5) t[d] = -1;
      end
    end
    cycle++;
    #1;
    for (int d = 0; d < 2; d++) begin
      int drv;
      check($sformatf("outs dut%0d cyc%0d", d, cycle), 64'(actual(d)),
            64'(expect_out(t[d], w_of(d), fld[d])));
      drv = ((rout[d] != 16'd0) ? 1 : 0) + int'(zlout[d]) + int'(zhout[d]);
      check($sformatf("bus_drivers dut%0d cyc%0d", d, cycle), 64'(drv <= 1), 64'(1));
      check($sformatf("onehot dut%0d cyc%0d", d, cycle),
            64'({$onehot0(rout[d]), $onehot0(rin[d])}), 64'(2'b11));
      if (done[d]) begin
        done_cnt[d]++;
        last_done[d] = cycle;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic launch(input logic dv, input logic tg, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] lo, input logic [3:0] hi);
    is_div = dv; to_gpr = tg; rb = b; rc = c; rd_lo = lo; rd_hi = hi;
    start = 1'b1;
    acc   = cycle;
    step();
    start = 1'b0;
    is_div = ~dv; rb = ~b; rc = ~c;  // later changes must not matter
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    gpr[0][idx] = v;
    gpr[1][idx] = v;
  endtask

  initial begin
    total = 0; bad = 0; cycle = 0; acc = 0;
    clear = 1'b0; start = 1'b0; is_div = 1'b0; to_gpr = 1'b0;
    rb = '0; rc = '0; rd_lo = '0; rd_hi = '0;
    for (int d = 0; d < 2; d++) begin
      t[d] = -1; fld[d] = '0; done_cnt[d] = 0; last_done[d] = 0;
      y_r[d] = '0; zhi[d] = '0; zlo[d] = '0; hi_r[d] = '0; lo_r[d] = '0;
      for (int i = 0; i < 16; i++) gpr[d][i] = '0;
    end

    // Reset: all outputs zero.
    run(2);
    clear = 1'b1;
    step();

    // MUL to LO/HI: 12 * 5.
    preload(2, 32'd12); preload(3, 32'd5);
    launch(1'b0, 1'b0, 4'd2, 4'd3, 4'd0, 4'd0);
    run(9);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mul_lo dut%0d", d), 64'(lo_r[d]), 64'd60);
      check($sformatf("mul_hi dut%0d", d), 64'(hi_r[d]), 64'd0);
      check($sformatf("latency1 dut%0d", d), 64'(last_done[d] - acc), 64'(w_of(d) + 5));
    end

    // DIV to GPRs: 17 / 5 -> R1=3, R0=2.
    preload(4, 32'd17); preload(5, 32'd5);
    launch(1'b1, 1'b1, 4'd4, 4'd5, 4'd1, 4'd0);
    run(9);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("div_q dut%0d", d), 64'(gpr[d][1]), 64'd3);
      check($sformatf("div_r dut%0d", d), 64'(gpr[d][0]), 64'd2);
      check($sformatf("latency2 dut%0d", d), 64'(last_done[d] - acc), 64'(w_of(d) + 5));
    end

    // Start held through EXEC and DONE, rb==rc.
    done_cnt[0] = 0; done_cnt[1] = 0;
    is_div = 1'b0; to_gpr = 1'b0; rb = 4'd6; rc = 4'd6;
    start = 1'b1;
    acc   = cycle;
    run(7);
    check("held_start_done_cnt dut0", 64'(done_cnt[0]), 64'd1);
    check("held_start_restart dut0", 64'(busy[0]), 64'd1);
    check("held_start_done_cnt dut1", 64'(done_cnt[1]), 64'd0);
    start = 1'b0;
    run(12);

    // Clear during WB_LO of dut0: abort, no HI write.
    preload(4, 32'hdead_beef);
    launch(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    run(2);
    clear = 1'b0;
    step();
    check("abort_outs dut0", 64'({busy[0], hiin[0], rin[0]}), 64'd0);
    check("abort_r4 dut0", 64'(gpr[0][4]), 64'hdead_beef);
    clear = 1'b1;
    step();
    launch(1'b0, 1'b0, 4'd2, 4'd3, 4'd0, 4'd0);
    run(9);
    check("after_abort latency dut0", 64'(last_done[0] - acc), 64'(W0 + 5));

    // rd_lo==rd_hi: Zhigh wins.
    preload(8, 32'h0001_0000); preload(9, 32'h0003_0005);
    launch(1'b0, 1'b1, 4'd8, 4'd9, 4'd7, 4'd7);
    run(9);
    for (int d = 0; d < 2; d++)
      check($sformatf("same_rd r7 dut%0d", d), 64'(gpr[d][7]), 64'd3);

    // Randomised traffic against the timeline model.
    repeat (400) begin
      clear  = ($urandom_range(0, 39) != 0);
      start  = ($urandom_range(0, 2) == 0);
      is_div = 1'($urandom);
      to_gpr = 1'($urandom);
      rb     = 4'($urandom);
      rc     = 4'($urandom);
      rd_lo  = 4'($urandom);
      rd_hi  = 4'($urandom);
      step();
    end
    clear = 1'b1;
    start = 1'b0;
    run(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Control-step sequencer for MUL and DIV instructions on the mini_cpu data_path.
- Replaces hand-driven control strobes with a registered FSM that runs the full sequence:
  - rb -> Y;
  - rc on bus with ALU op -> ZHigh/Zlow;
  - Zlow -> LO or GPR;
  - Zhigh -> HI or GPR.
- Sits between the instruction decoder (start + register fields) and the data_path control inputs.
- Drives one-hot register out/in enables plus the Y, Z, HI and LO strobes.

Parameters:
- OP_MUL, 5'b01010, ALU op code driven on op for multiply.
- OP_DIV, 5'b01011, ALU op code driven on op for divide.
- ALU_WAIT, 0, extra cycles the EXEC state holds before the Z capture (0..15).

Ports:
- Clock  in  1  system clock; all state and outputs update on its rising edge.
- clear  in  1  synchronous active-low reset.
- start  in  1  request pulse; accepted only in IDLE.
- is_div  in  1  0 = multiply, 1 = divide; sampled on accept.
- rb  in  4  first operand register index (goes to Y).
- rc  in  4  second operand register index (driven with op).
- to_gpr  in  1  0 = write back to LO/HI; 1 = write back to GPRs.
- rd_lo  in  4  GPR index for Zlow when to_gpr=1.
- rd_hi  in  4  GPR index for Zhigh when to_gpr=1.
- Rout  out  16  one-hot GPR bus-out enables (bit n = Rn out).
- Rin  out  16  one-hot GPR load enables.
- Yin  out  1  Y register load.
- op  out  5  ALU operation select.
- ZHighin  out  1  Z high load.
- Zlowin  out  1  Z low load.
- Zhighout  out  1  Z high to bus.
- Zlowout  out  1  Z low to bus.
- HIin  out  1  HI load.
- LOin  out  1  LO load.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: clear=0 sampled at a rising edge -> state IDLE, wait counter 0. Every output is 0: Rout, Rin, op, all strobes, busy, done.
- Reset mid-sequence aborts immediately. No write-back is completed. Outputs are 0 from the following cycle.
- All outputs are registered. At most one bus driver is asserted in any cycle.
- IDLE:
  - busy=0, all strobes 0, op=0.
  - If start=1, latch is_div, rb, rc, to_gpr, rd_lo, rd_hi and go to LOAD_Y.
- LOAD_Y (1 cycle): Rout[rb]=1, Yin=1, busy=1.
- EXEC (ALU_WAIT+1 cycles):
  - Rout[rc]=1 and op = OP_DIV if is_div, else OP_MUL, held for the whole state.
  - A 4-bit wait counter counts 0..ALU_WAIT.
  - ZHighin=Zlowin=1 only in the final EXEC cycle (counter==ALU_WAIT).
  - op returns to 0 on leaving EXEC.
- WB_LO (1 cycle): Zlowout=1. If to_gpr=0, LOin=1; else Rin[rd_lo]=1.
- WB_HI (1 cycle): Zhighout=1. If to_gpr=0, HIin=1; else Rin[rd_hi]=1.
- DONE (1 cycle): done=1, busy=0, all strobes 0. Next state IDLE.
- busy=1 exactly in LOAD_Y, EXEC, WB_LO and WB_HI.
- Latency: start accepted at edge k -> LOAD_Y outputs in cycle k+1 -> done in cycle k+5+ALU_WAIT.
- Back-to-back: start asserted during DONE is ignored. A new start is accepted in the following IDLE cycle.
- Boundary cases:
  - start while busy: ignored and not queued.
  - Input changes after accept have no effect, because fields are latched.
  - rb==rc: legal; the same register is driven in LOAD_Y and in EXEC.
  - to_gpr=1 with rd_lo==rd_hi: both writes occur and Zhigh (later) wins.
  - rd_lo==rb or rd_lo==rc: legal, because operands were consumed before write-back.
  - ALU_WAIT is treated modulo 16.

Test Plan:
1. Reset then MUL, to_gpr=0, rb=2, rc=3, ALU_WAIT=0:
   - Start in cycle 0 -> cycle 1: Rout=16'h0004, Yin=1.
   - Cycle 2: Rout=16'h0008, op=5'b01010, ZHighin=Zlowin=1.
   - Cycle 3: Zlowout=1, LOin=1.
   - Cycle 4: Zhighout=1, HIin=1.
   - Cycle 5: done=1. With data_path R2=12, R3=5 -> LO=60, HI=0.
2. DIV, to_gpr=1, rb=4, rc=5, rd_lo=1, rd_hi=0, ALU_WAIT=3:
   - EXEC lasts 4 cycles with op=5'b01011 and Rout=16'h0020.
   - Z loads only in the 4th EXEC cycle.
   - WB_LO: Rin=16'h0002. WB_HI: Rin=16'h0001.
   - done arrives 8 cycles after accept. With R4=17, R5=5 -> R1=3, R0=2.
3. Start pulsed again during EXEC and during DONE:
   - No restart and done pulses once.
   - Start held in the next IDLE cycle begins a new sequence.
4. clear=0 asserted during WB_LO:
   - Next cycle: all outputs 0, busy=0, no HIin or Rin pulse.
   - A subsequent start runs a full sequence.
5. to_gpr=1, rd_lo=rd_hi=7:
   - Rin[7] pulses in both WB cycles; the final R7 value equals Zhigh.
6. Protocol checker across all cases:
   - At most one of Rout, Zlowout, Zhighout is nonzero per cycle.
   - Rout and Rin are always zero or one-hot.
   - op is nonzero only in EXEC.
